// File: rtl/fir_coef_reload_streamer_if.sv
// AXI-Stream reload (coefficient) and config channels towards the FIR Compiler.
// master drives data/valid/last, slave drives the ready signals.
interface fir_coef_reload_streamer_if #(
   parameter int COEF_W = 16
);
   logic [COEF_W-1:0] reload_tdata;
   logic              reload_tvalid;
   logic              reload_tready;
   logic              reload_tlast;
   logic [7:0]        config_tdata;
   logic              config_tvalid;
   logic              config_tready;

   modport master (
      output reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid,
      input  reload_tready, config_tready
   );

   modport slave (
      input  reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid,
      output reload_tready, config_tready
   );
endinterface

// File: rtl/fir_coef_reload_streamer.sv
// Double-banked FIR coefficient store: swap_req flips banks and streams the new active bank, first tvalid 2 cycles later.
// Full-rate stream under tready via read-ahead plus skid register; config beat after CONF_DELAY+1 idle cycles.
module fir_coef_reload_streamer #(
   parameter int NUM_COEF   = 192,
   parameter int COEF_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int CONF_DELAY = 200
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_en,
   input  logic [ADDR_W-1:0]                   wr_addr,
   input  logic [COEF_W-1:0]                   wr_data,
   input  logic                                swap_req,
   fir_coef_reload_streamer_if.master          m_axis,
   output logic                                busy,
   output logic                                done,
   output logic                                err_busy,
   output logic                                active_bank
);
   typedef enum logic [1:0] {IDLE, STREAM, GAP, CONF} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEF - 1);
   localparam int                GAP_W    = $clog2(CONF_DELAY + 1);
   localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(CONF_DELAY);

   state_t state, state_nxt;

   logic [COEF_W-1:0] mem [0:1][0:NUM_COEF-1];
   logic [COEF_W-1:0] ram_q;
   logic [ADDR_W-1:0] rd_idx;
   logic              rd_done, rd_pend, rd_last;
   logic              out_vld, out_last, skid_vld, skid_last;
   logic [COEF_W-1:0] out_dat, skid_dat;
   logic [GAP_W-1:0]  gap_cnt;
   logic [1:0]        occ;
   logic              pop, issue;

   assign pop   = out_vld && m_axis.reload_tready;
   // Beats in flight (RAM read, skid, output); keep at most two so the skid never overflows.
   assign occ   = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_pend};
   assign issue = (state == STREAM) && !rd_done && ((occ - {1'b0, pop}) < 2'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (swap_req)                state_nxt = STREAM;
         STREAM:  if (pop && out_last)         state_nxt = GAP;
         GAP:     if (gap_cnt == GAP_END)      state_nxt = CONF;
         CONF:    if (m_axis.config_tready)    state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Shadow bank is never the bank being read, so reads and writes cannot collide.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr <= LAST_IDX)) mem[~active_bank][wr_addr] <= wr_data;
      if (issue)                          ram_q <= mem[active_bank][rd_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_bank <= 1'b0;
         rd_idx      <= '0;
         rd_done     <= 1'b0;
         rd_pend     <= 1'b0;
         rd_last     <= 1'b0;
         out_vld     <= 1'b0;
         out_dat     <= '0;
         out_last    <= 1'b0;
         skid_vld    <= 1'b0;
         skid_dat    <= '0;
         skid_last   <= 1'b0;
         gap_cnt     <= '0;
         done        <= 1'b0;
         err_busy    <= 1'b0;
      end else begin
         done     <= (state == CONF) && m_axis.config_tready;
         err_busy <= swap_req && (state != IDLE);

         if ((state == IDLE) && swap_req) begin
            active_bank <= ~active_bank;
            rd_idx      <= '0;
            rd_done     <= 1'b0;
         end else if (issue) begin
            if (rd_idx == LAST_IDX) rd_done <= 1'b1;
            else                    rd_idx  <= rd_idx + 1'b1;
         end
         rd_pend <= issue;
         rd_last <= issue && (rd_idx == LAST_IDX);

         if (pop || !out_vld) begin
            if (skid_vld) begin
               out_vld   <= 1'b1;
               out_dat   <= skid_dat;
               out_last  <= skid_last;
               skid_vld  <= rd_pend;
               skid_dat  <= ram_q;
               skid_last <= rd_last;
            end else begin
               out_vld <= rd_pend;
               if (rd_pend) begin
                  out_dat  <= ram_q;
                  out_last <= rd_last;
               end
            end
         end else if (rd_pend) begin
            skid_vld  <= 1'b1;
            skid_dat  <= ram_q;
            skid_last <= rd_last;
         end

         if (state != GAP) gap_cnt <= '0;
         else              gap_cnt <= gap_cnt + 1'b1;
      end
   end

   assign m_axis.reload_tdata  = out_dat;
   assign m_axis.reload_tvalid = out_vld;
   assign m_axis.reload_tlast  = out_vld && out_last;
   assign m_axis.config_tdata  = 8'h00;
   assign m_axis.config_tvalid = (state == CONF);
   assign busy                 = (state != IDLE);
endmodule

// File: tb/tb_fir_coef_reload_streamer.sv
// Randomised bench for fir_coef_reload_streamer against a bank-array reference model.
module tb_fir_coef_reload_streamer;
   localparam int NUM_COEF   = 192;
   localparam int COEF_W     = 16;
   localparam int ADDR_W     = 8;
   localparam int CONF_DELAY = 200;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [COEF_W-1:0] wr_data = '0;
   logic              swap_req = 1'b0;
   logic              busy, done, err_busy, active_bank;

   always #5 clk = ~clk;

   fir_coef_reload_streamer_if #(.COEF_W(COEF_W)) axis ();

   fir_coef_reload_streamer #(
      .NUM_COEF(NUM_COEF), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .CONF_DELAY(CONF_DELAY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .m_axis(axis), .busy(busy), .done(done),
      .err_busy(err_busy), .active_bank(active_bank)
   );

   int checks = 0;
   int failures = 0;

   logic [COEF_W-1:0] mdl [0:1][0:NUM_COEF-1];
   logic              mact = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_write(input int addr, input logic [COEF_W-1:0] d);
      if (addr < NUM_COEF) mdl[!mact][addr] = d;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_tvalid"}, 32'(axis.reload_tvalid), 0);
      check_eq({pfx, "_tlast"},  32'(axis.reload_tlast), 0);
      check_eq({pfx, "_tdata"},  32'(axis.reload_tdata), 0);
      check_eq({pfx, "_cvalid"}, 32'(axis.config_tvalid), 0);
      check_eq({pfx, "_busy"},   32'(busy), 0);
      check_eq({pfx, "_done"},   32'(done), 0);
      check_eq({pfx, "_err"},    32'(err_busy), 0);
      check_eq({pfx, "_bank"},   32'(active_bank), 0);
   endtask

   task automatic write_coef(input int addr, input logic [COEF_W-1:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(addr);
      wr_data = d;
      model_write(addr, d);
   endtask

   task automatic run_packet(input bit rand_rdy, input int conf_hold, input bit inject_err,
                             input bit same_cycle_wr, input bit shadow_wr, input int reset_at);
      logic [COEF_W-1:0] exp [0:NUM_COEF-1];
      logic [COEF_W-1:0] held_dat;
      logic              held_last, rdy, cr;
      int c = -1, nbeats = 0, t_last = -1, conf_cnt = 0, quiet = 0;
      bit seen_first = 0, hold_pend = 0, err_pend = 0, conf_seen = 0;
      bit beat_err_done = 0, gap_err_done = 0, post_last = 0, conf_done_pend = 0;

      @(negedge clk);
      swap_req = 1'b1;
      wr_en    = 1'b0;
      if (same_cycle_wr) begin
         wr_en   = 1'b1;
         wr_addr = '0;
         wr_data = 16'hABCD;
         model_write(0, 16'hABCD);
      end
      mact = !mact;
      for (int k = 0; k < NUM_COEF; k++) exp[k] = mdl[mact][k];

      while (1) begin
         @(negedge clk);
         c++;
         swap_req = 1'b0;
         wr_en    = 1'b0;
         if (c > 3000) begin
            check_eq("pkt_timeout_done", 32'(done), 1);
            break;
         end
         if (conf_done_pend) begin
            check_eq("done_after_hs", 32'(done), 1);
            check_eq("busy_after_hs", 32'(busy), 0);
            check_eq("cvalid_after_hs", 32'(axis.config_tvalid), 0);
            axis.config_tready = 1'b0;
            axis.reload_tready = 1'b0;
            @(negedge clk);
            check_eq("done_pulse_len", 32'(done), 0);
            break;
         end
         if (c == 0) begin
            check_eq("swap_bank", 32'(active_bank), 32'(mact));
            check_eq("swap_busy", 32'(busy), 1);
         end
         if (err_pend) begin
            check_eq("err_busy", 32'(err_busy), 1);
            check_eq("err_bank", 32'(active_bank), 32'(mact));
            err_pend = 0;
         end
         if (hold_pend) begin
            check_eq("stall_tvalid", 32'(axis.reload_tvalid), 1);
            check_eq("stall_tdata", 32'(axis.reload_tdata), 32'(held_dat));
            check_eq("stall_tlast", 32'(axis.reload_tlast), 32'(held_last));
            hold_pend = 0;
         end
         if (post_last) begin
            check_eq("post_last_tvalid", 32'(axis.reload_tvalid), 0);
            post_last = 0;
         end
         if (reset_at >= 0 && nbeats == reset_at) begin
            rst_n = 1'b0;
            axis.reload_tready = 1'b0;
            axis.config_tready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_reset_outputs("midrst");
            mact = 1'b0;
            repeat (CONF_DELAY + 50) begin
               @(negedge clk);
               if (axis.reload_tvalid || axis.reload_tlast || axis.config_tvalid || done) quiet++;
            end
            check_eq("rst_quiet", quiet, 0);
            return;
         end
         if (axis.reload_tvalid && !seen_first) begin
            check_eq("first_latency", c, 2);
            seen_first = 1;
         end

         rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         axis.reload_tready = rdy;
         if (axis.reload_tvalid) begin
            if (nbeats >= NUM_COEF) begin
               check_eq("extra_beat", nbeats, NUM_COEF - 1);
            end else if (rdy) begin
               check_eq("beat_data", 32'(axis.reload_tdata), 32'(exp[nbeats]));
               check_eq("beat_tlast", 32'(axis.reload_tlast), 32'(nbeats == NUM_COEF - 1));
               if (nbeats == NUM_COEF - 1) begin
                  t_last    = c;
                  post_last = 1;
               end
               nbeats++;
            end else begin
               hold_pend = 1;
               held_dat  = axis.reload_tdata;
               held_last = axis.reload_tlast;
            end
         end

         if (inject_err && !beat_err_done && nbeats == 50) begin
            swap_req = 1'b1;
            err_pend = 1;
            beat_err_done = 1;
         end
         if (inject_err && !gap_err_done && t_last >= 0 && c == t_last + 20) begin
            swap_req = 1'b1;
            err_pend = 1;
            gap_err_done = 1;
         end
         if (shadow_wr && nbeats < NUM_COEF && $urandom_range(0, 3) == 0) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'($urandom_range(0, 255));
            wr_data = COEF_W'($urandom);
            model_write(int'(wr_addr), wr_data);
         end

         if (axis.config_tvalid) begin
            if (!conf_seen) begin
               check_eq("conf_latency", c, t_last + 1 + CONF_DELAY + 1);
               check_eq("conf_tdata", 32'(axis.config_tdata), 0);
               check_eq("beat_count", nbeats, NUM_COEF);
               conf_seen = 1;
            end
            check_eq("done_early", 32'(done), 0);
            cr = (conf_cnt >= conf_hold);
            axis.config_tready = cr;
            conf_cnt++;
            if (cr) conf_done_pend = 1;
         end else begin
            axis.config_tready = 1'b0;
         end
      end
   endtask

   initial begin
      axis.reload_tready = 1'b0;
      axis.config_tready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      for (int k = 0; k < NUM_COEF; k++) write_coef(k, COEF_W'(k + 1));
      write_coef(200, 16'hDEAD);
      @(negedge clk);
      wr_en = 1'b0;
      run_packet(0, 0, 0, 0, 0, -1);

      for (int k = 0; k < NUM_COEF; k++) write_coef(k, COEF_W'($urandom));
      @(negedge clk);
      wr_en = 1'b0;
      run_packet(1, 10, 1, 0, 1, -1);

      run_packet(1, 0, 0, 1, 1, -1);
      run_packet(1, 0, 0, 0, 0, 100);
      run_packet(0, 0, 0, 0, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fir_coef_reload_streamer.md
Name: fir_coef_reload_streamer

Overview:
- Downstream neighbour of the reload strobe synchroniser; the source of the FIR Compiler reload/config channels.
- Holds two banks of FIR coefficients: host writes go to the shadow bank.
- On a reload request it swaps banks and streams the new active bank as an AXI-Stream reload packet, with tlast on the last coefficient.
- After a programmable gap it issues one config-channel beat that commits the new coefficients.

Parameters:
- NUM_COEF, 192: coefficients per packet; last index NUM_COEF-1.
- COEF_W, 16: coefficient width.
- ADDR_W, 8: coefficient address width; 2^ADDR_W must be >= NUM_COEF.
- CONF_DELAY, 200: idle cycles between the tlast handshake and config tvalid assertion. Minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  coefficient write strobe, targets the shadow bank.
- wr_addr  in  ADDR_W  coefficient index.
- wr_data  in  COEF_W  coefficient value.
- swap_req  in  1  single-cycle reload request, already synchronised to clk.
- m_axis_reload_tdata  out  COEF_W  coefficient beat.
- m_axis_reload_tvalid  out  1  beat valid.
- m_axis_reload_tready  in  1  sink ready.
- m_axis_reload_tlast  out  1  marks beat NUM_COEF-1.
- m_axis_config_tdata  out  8  config word, constant 8'h00.
- m_axis_config_tvalid  out  1  config beat valid.
- m_axis_config_tready  in  1  config sink ready.
- busy  out  1  high from swap acceptance until done.
- done  out  1  one-cycle pulse after the config handshake.
- err_busy  out  1  one-cycle pulse when swap_req is dropped.
- active_bank  out  1  bank currently designated for streaming.

Behaviour:
- Reset (rst_n=0 at a clock edge): on the next edge, all outputs are 0, including active_bank=0. FSM goes to IDLE and all counters clear. RAM contents are preserved. Reset mid-packet aborts the packet with no tlast and no config beat.
- Storage: 2 x NUM_COEF x COEF_W RAM with a 1-cycle read.
  - A write goes to bank ~active_bank when wr_en=1 and wr_addr < NUM_COEF.
  - wr_addr >= NUM_COEF is silently ignored.
  - Writes are accepted in every state. While busy, the shadow bank is never the bank being read.
- FSM states: IDLE, STREAM, GAP, CONF.
- IDLE:
  - swap_req=1 toggles active_bank, sets busy=1, moves to STREAM and clears the beat index.
  - If wr_en is high in the same cycle as an accepted swap_req, the write lands in the pre-swap shadow bank, i.e. the new active bank. It must be visible in the packet, including at index 0.
- STREAM:
  - First tvalid rises exactly 2 cycles after the swap_req edge, i.e. the cycle-0 sample gives tvalid at cycle 2.
  - Beat k carries RAM[active_bank][k].
  - AXI rules: once tvalid=1, tdata, tlast and tvalid hold until tready=1. tvalid never depends on tready.
  - Throughput is 1 beat/cycle while tready stays high. This requires read-ahead plus a skid register; no bubbles are allowed.
  - tlast=1 only on beat NUM_COEF-1.
  - The tlast handshake deasserts tvalid on the next edge and moves to GAP.
- GAP:
  - Counts CONF_DELAY cycles.
  - config tvalid rises exactly CONF_DELAY+1 cycles after the tlast handshake edge; then move to CONF.
- CONF:
  - m_axis_config_tvalid=1 with tdata 8'h00, held until tready.
  - On handshake: tvalid drops, done pulses for 1 cycle, busy drops in that same cycle, FSM returns to IDLE.
- swap_req in any state other than IDLE: ignored, err_busy pulses in the following cycle, active_bank unchanged.
- swap_req arriving in the same cycle done is high is accepted, because the FSM is already in IDLE.
- Beat index is ADDR_W wide and never wraps past NUM_COEF-1.

Test Plan:
1. Reset, write bank 1 with coef[k]=k+1 (k=0..191), swap_req with tready=1 -> active_bank=1, tvalid at cycle 2, 192 consecutive beats with data 1..192, tlast only on data 192, config tvalid exactly 201 cycles after the tlast edge, done pulse, busy low.
2. Same packet with tready toggling 1-0-0-1 randomly -> no dropped or duplicated beats, data stable while stalled, still 192 beats.
3. swap_req pulsed at beat 50 and during GAP -> err_busy pulse each time, packet unaffected, active_bank unchanged; second swap after done -> streams bank 0.
4. wr_en with addr 0, data 16'hABCD in the swap_req cycle -> first beat is 16'hABCD. Write to addr 200 -> no RAM change. Writes to the shadow bank mid-packet -> streamed data unaffected.
5. Config tready held low 10 cycles -> config tvalid stays high 10+ cycles, done only after the handshake.
6. rst_n low at beat 100 -> next edge: all outputs 0, active_bank=0, no tlast/config. The new swap streams the previously written bank-1 data from index 0.
